// File: rtl/atmega_rng_adc_ctrl.sv
// rtl/atmega_rng_adc_ctrl.sv - ATmega-style ADC register block whose conversion source is an LFSR
// Firmware sees ADCL/ADCH/ADCSRA/ADCSRB/ADMUX with real conversion latency and ADC data read lock.

module atmega_rng_adc_ctrl #(
  parameter string                          PLATFORM          = "XILINX",
  parameter int                             BUS_ADDR_DATA_LEN = 8,
  parameter int                             RNG_BIT_NR        = 10,
  parameter int                             CHANNEL_NR        = 8,
  parameter logic [15:0]                    BANDGAP_VALUE     = 16'h15E,
  parameter logic [BUS_ADDR_DATA_LEN-1:0]   ADCL_ADDR         = 'h78,
  parameter logic [BUS_ADDR_DATA_LEN-1:0]   ADCH_ADDR         = 'h79,
  parameter logic [BUS_ADDR_DATA_LEN-1:0]   ADCSRA_ADDR       = 'h7A,
  parameter logic [BUS_ADDR_DATA_LEN-1:0]   ADCSRB_ADDR       = 'h7B,
  parameter logic [BUS_ADDR_DATA_LEN-1:0]   ADMUX_ADDR        = 'h7C
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BUS_ADDR_DATA_LEN-1:0] addr,
  input  logic                         wr,
  input  logic                         rd,
  input  logic [7:0]                   bus_in,
  output logic [7:0]                   bus_out,
  output logic                         int_o,
  input  logic                         int_ack
);

  localparam int N = RNG_BIT_NR;

  // Maximal-length Fibonacci tap masks for a left-shifting register
  localparam logic [15:0] TAPS =
      (N == 8)  ? 16'h00B8 :
      (N == 9)  ? 16'h0110 :
      (N == 10) ? 16'h0240 :
      (N == 11) ? 16'h0500 :
      (N == 12) ? 16'h0829 :
      (N == 13) ? 16'h100D :
      (N == 14) ? 16'h2015 :
      (N == 15) ? 16'h6000 :
                  16'hD008;

  localparam logic [4:0] CH_LIMIT = 5'(CHANNEL_NR);

  typedef enum logic {S_IDLE, S_CONV} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] lfsr_q, lfsr_d;
  logic [N-1:0] result_q, result_d;
  logic         aden_q, aden_d;
  logic         adate_q, adate_d;
  logic         adif_q, adif_d;
  logic         adie_q, adie_d;
  logic [2:0]   adps_q, adps_d;
  logic [2:0]   adts_q, adts_d;
  logic [1:0]   refs_q, refs_d;
  logic         adlar_q, adlar_d;
  logic [3:0]   mux_q, mux_d;
  logic [3:0]   mux_lat_q, mux_lat_d;
  logic         lock_q, lock_d;
  logic [6:0]   presc_q, presc_d;
  logic [4:0]   tick_q, tick_d;
  logic         first_q, first_d;

  logic         lfsr_fb;
  logic         wr_adcsra, wr_adcsrb, wr_admux;
  logic         rd_adcl, rd_adch;
  logic [6:0]   div_m1;
  logic [4:0]   conv_len_m1;
  logic         adc_tick;
  logic [N-1:0] conv_value;
  logic [15:0]  res_ext;
  logic [15:0]  adc16;
  logic         adsc;
  logic         unused_platform;

  assign unused_platform = (PLATFORM == "XILINX");

  assign lfsr_fb   = ^(lfsr_q & TAPS[N-1:0]);
  assign wr_adcsra = wr && (addr == ADCSRA_ADDR);
  assign wr_adcsrb = wr && (addr == ADCSRB_ADDR);
  assign wr_admux  = wr && (addr == ADMUX_ADDR);
  assign rd_adcl   = rd && (addr == ADCL_ADDR);
  assign rd_adch   = rd && (addr == ADCH_ADDR);
  assign adsc      = (state_q == S_CONV);

  // ADPS=0 divides by 2 like ADPS=1
  always_comb begin
    div_m1 = 7'd1;
    case (adps_q)
      3'd2:    div_m1 = 7'd3;
      3'd3:    div_m1 = 7'd7;
      3'd4:    div_m1 = 7'd15;
      3'd5:    div_m1 = 7'd31;
      3'd6:    div_m1 = 7'd63;
      3'd7:    div_m1 = 7'd127;
      default: div_m1 = 7'd1;
    endcase
  end

  assign conv_len_m1 = first_q ? 5'd24 : 5'd12;
  assign adc_tick    = (presc_q == div_m1);

  always_comb begin
    conv_value = '0;
    if ({1'b0, mux_lat_q} < CH_LIMIT) begin
      conv_value = lfsr_q;
    end else if (mux_lat_q == 4'hE) begin
      conv_value = BANDGAP_VALUE[N-1:0];
    end
  end

  assign res_ext = 16'(result_q);
  assign adc16   = adlar_q ? (res_ext << (16 - N)) : res_ext;
  assign int_o   = adif_q & adie_q;

  always_comb begin
    bus_out = 8'h00;
    if (rd && !rst) begin
      if (addr == ADCL_ADDR) begin
        bus_out = adc16[7:0];
      end else if (addr == ADCH_ADDR) begin
        bus_out = adc16[15:8];
      end else if (addr == ADCSRA_ADDR) begin
        bus_out = {aden_q, adsc, adate_q, adif_q, adie_q, adps_q};
      end else if (addr == ADCSRB_ADDR) begin
        bus_out = {5'b00000, adts_q};
      end else if (addr == ADMUX_ADDR) begin
        bus_out = {refs_q, adlar_q, 1'b0, mux_q};
      end
    end
  end

  always_comb begin
    lfsr_d    = {lfsr_q[N-2:0], lfsr_fb};
    state_d   = state_q;
    result_d  = result_q;
    aden_d    = aden_q;
    adate_d   = adate_q;
    adif_d    = adif_q;
    adie_d    = adie_q;
    adps_d    = adps_q;
    adts_d    = adts_q;
    refs_d    = refs_q;
    adlar_d   = adlar_q;
    mux_d     = mux_q;
    mux_lat_d = mux_lat_q;
    lock_d    = lock_q;
    presc_d   = presc_q;
    tick_d    = tick_q;
    first_d   = first_q;

    if (wr_adcsra) begin
      aden_d  = bus_in[7];
      adate_d = bus_in[5];
      adie_d  = bus_in[3];
      adps_d  = bus_in[2:0];
      if (!bus_in[7]) begin
        first_d = 1'b1;
      end
    end
    if (wr_adcsrb) begin
      adts_d = bus_in[2:0];
    end
    if (wr_admux) begin
      refs_d  = bus_in[7:6];
      adlar_d = bus_in[5];
      mux_d   = bus_in[3:0];
    end

    if (rd_adcl) begin
      lock_d = 1'b1;
    end else if (rd_adch) begin
      lock_d = 1'b0;
    end

    // Clear first so a completion on the same edge sets ADIF again
    if ((wr_adcsra && bus_in[4]) || int_ack) begin
      adif_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (wr_adcsra && bus_in[7] && bus_in[6]) begin
          state_d   = S_CONV;
          mux_lat_d = mux_q;
          presc_d   = '0;
          tick_d    = '0;
        end
      end
      S_CONV: begin
        if (wr_adcsra && !bus_in[7]) begin
          state_d = S_IDLE;
        end else if (adc_tick) begin
          presc_d = '0;
          if (tick_q == conv_len_m1) begin
            if (!lock_q) begin
              result_d = conv_value;
            end
            adif_d  = 1'b1;
            first_d = 1'b0;
            if (adate_q && (adts_q == 3'b000)) begin
              mux_lat_d = mux_q;
              tick_d    = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end else begin
          presc_d = presc_q + 7'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      lfsr_q    <= '1;
      result_q  <= '0;
      aden_q    <= 1'b0;
      adate_q   <= 1'b0;
      adif_q    <= 1'b0;
      adie_q    <= 1'b0;
      adps_q    <= '0;
      adts_q    <= '0;
      refs_q    <= '0;
      adlar_q   <= 1'b0;
      mux_q     <= '0;
      mux_lat_q <= '0;
      lock_q    <= 1'b0;
      presc_q   <= '0;
      tick_q    <= '0;
      first_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      result_q  <= result_d;
      aden_q    <= aden_d;
      adate_q   <= adate_d;
      adif_q    <= adif_d;
      adie_q    <= adie_d;
      adps_q    <= adps_d;
      adts_q    <= adts_d;
      refs_q    <= refs_d;
      adlar_q   <= adlar_d;
      mux_q     <= mux_d;
      mux_lat_q <= mux_lat_d;
      lock_q    <= lock_d;
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      first_q   <= first_d;
    end
  end

endmodule
